// File: rtl/platform_utils_ccip_tx_fifo_pkg.sv
// Shared types for the CCI-P Tx buffering shim: channel structs, FIFO entry
// layouts and the pointer/count width helpers used by the per-channel FIFOs.
package platform_utils_ccip_tx_fifo_pkg;

   localparam int CL_DATA_WIDTH         = 512;
   localparam int MMIO_DATA_WIDTH       = 64;
   localparam int MMIO_TID_WIDTH        = 9;
   localparam int DEFAULT_DEPTH         = 64;
   localparam int DEFAULT_ALMFULL_SLACK = 8;

   // Pointers wrap naturally at DEPTH; the count needs one extra bit to hold DEPTH itself.
   function automatic int ptrWidth(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int countWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int DEFAULT_PTR_WIDTH   = ptrWidth(DEFAULT_DEPTH);
   localparam int DEFAULT_COUNT_WIDTH = countWidth(DEFAULT_DEPTH);

   typedef enum logic [1:0] {
      eVC_VA  = 2'b00,
      eVC_VL0 = 2'b01,
      eVC_VH0 = 2'b10,
      eVC_VH1 = 2'b11
   } t_ccip_vc;

   typedef struct packed {
      t_ccip_vc    vcSel;
      logic [1:0]  rsvd1;
      logic [1:0]  clLen;
      logic [3:0]  reqType;
      logic [5:0]  rsvd0;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [5:0]  rsvd2;
      t_ccip_vc    vcSel;
      logic        sop;
      logic        rsvd1;
      logic [1:0]  clLen;
      logic [3:0]  reqType;
      logic [5:0]  rsvd0;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      logic [MMIO_TID_WIDTH-1:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_vc    vcUsed;
      logic        rsvd1;
      logic        hitMiss;
      logic [1:0]  rsvd0;
      logic [1:0]  clNum;
      logic [3:0]  respType;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_vc    vcUsed;
      logic        rsvd1;
      logic        hitMiss;
      logic        format;
      logic        rsvd0;
      logic [1:0]  clNum;
      logic [3:0]  respType;
      logic [15:0] mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr       hdr;
      logic [CL_DATA_WIDTH-1:0] data;
      logic                     valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr        hdr;
      logic                       mmioRdValid;
      logic [MMIO_DATA_WIDTH-1:0] data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   typedef struct packed {
      t_ccip_c0_RspMemHdr       hdr;
      logic [CL_DATA_WIDTH-1:0] data;
      logic                     rspValid;
      logic                     mmioRdValid;
      logic                     mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

   typedef t_ccip_c0_ReqMemHdr t_c0_fifo_entry;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr       hdr;
      logic [CL_DATA_WIDTH-1:0] data;
   } t_c1_fifo_entry;

endpackage

// File: rtl/platform_utils_ccip_tx_fifo_chan_fifo.sv
// Fall-through FIFO for one CCI-P Tx channel: an enqueue into an empty FIFO is
// visible at the head in the same cycle so it can be popped without a bubble.
module platform_utils_ccip_tx_chan_fifo
   import platform_utils_ccip_tx_fifo_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int ALMFULL_SLACK = DEFAULT_ALMFULL_SLACK
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_en,
   input  logic [WIDTH-1:0] enq_data,
   input  logic             deq_en,
   output logic [WIDTH-1:0] first,
   output logic             notEmpty,
   output logic             almFull,
   output logic             overflow
);

   localparam int PW = ptrWidth(DEPTH);
   localparam int CW = countWidth(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT    = CW'(DEPTH);
   localparam logic [CW-1:0] ALMFULL_COUNT = CW'(DEPTH - ALMFULL_SLACK);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    countNext;
   logic             isEmpty;
   logic             isFull;
   logic             doDeq;
   logic             enqAccept;
   logic             memWrite;
   logic             memRead;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a beat
   // alongside a dequeue; a beat that bypasses an empty FIFO never touches storage.
   always_comb begin
      isEmpty   = (count == '0);
      isFull    = (count == FULL_COUNT);
      notEmpty  = !isEmpty || enq_en;
      first     = isEmpty ? enq_data : mem[rdPtr];
      doDeq     = deq_en && notEmpty;
      enqAccept = enq_en && (!isFull || doDeq);
      overflow  = enq_en && !enqAccept;
      memWrite  = enqAccept && !(isEmpty && doDeq);
      memRead   = doDeq && !isEmpty;
      countNext = count;
      if (memWrite && !memRead) begin
         countNext = count + CW'(1);
      end else if (!memWrite && memRead) begin
         countNext = count - CW'(1);
      end
   end

   // Storage has no reset; validity is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (memWrite) begin
         mem[wrPtr] <= enq_data;
      end
   end

   // Almost-full looks at the next-state count so the flag lines up with the
   // cycle in which the occupancy actually reaches the threshold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         almFull <= 1'b0;
      end else begin
         if (memWrite) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (memRead) begin
            rdPtr <= rdPtr + PW'(1);
         end
         count   <= countNext;
         almFull <= (countNext >= ALMFULL_COUNT);
      end
   end

endmodule

// File: rtl/platform_utils_ccip_tx_fifo.sv
// AFU-side CCI-P Tx buffer: per-channel FIFOs for c0/c1, registered c2 pass-through,
// AFU almost-full with slack. Optional sticky overflow flag via PLATFORM_UTILS_CCIP_TX_FIFO_OVERFLOW_CHECK_EN.
module platform_utils_ccip_tx_fifo
   import platform_utils_ccip_tx_fifo_pkg::*;
#(
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int ALMFULL_SLACK = DEFAULT_ALMFULL_SLACK
)
(
   input  logic        clk,
   input  logic        reset,
   input  t_if_ccip_Tx afu_tx,
   output t_if_ccip_Rx afu_rx,
   output t_if_ccip_Tx fiu_tx,
   input  t_if_ccip_Rx fiu_rx,
   output logic        error
);

   logic [1:0]     resetSync;
   logic           rstInt;
   t_c0_fifo_entry c0Head;
   t_c1_fifo_entry c1Head;
   t_c1_fifo_entry c1EnqEntry;
   logic           c0NotEmpty;
   logic           c1NotEmpty;
   logic           c0AlmFull;
   logic           c1AlmFull;
   logic           c0Overflow;
   logic           c1Overflow;
   logic           c0Deq;
   logic           c1Deq;

   // Reset asserts immediately but releases two clocks later so every flop
   // leaves reset on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resetSync <= 2'b11;
      end else begin
         resetSync <= {resetSync[0], 1'b0};
      end
   end

   assign rstInt     = resetSync[1];
   assign c1EnqEntry = '{hdr: afu_tx.c1.hdr, data: afu_tx.c1.data};
   assign c0Deq      = c0NotEmpty && !fiu_rx.c0TxAlmFull;
   assign c1Deq      = c1NotEmpty && !fiu_rx.c1TxAlmFull;

   platform_utils_ccip_tx_chan_fifo #(
      .WIDTH        ($bits(t_c0_fifo_entry)),
      .DEPTH        (DEPTH),
      .ALMFULL_SLACK(ALMFULL_SLACK)
   ) c0Fifo (
      .clk     (clk),
      .reset   (rstInt),
      .enq_en  (afu_tx.c0.valid),
      .enq_data(afu_tx.c0.hdr),
      .deq_en  (c0Deq),
      .first   (c0Head),
      .notEmpty(c0NotEmpty),
      .almFull (c0AlmFull),
      .overflow(c0Overflow)
   );

   platform_utils_ccip_tx_chan_fifo #(
      .WIDTH        ($bits(t_c1_fifo_entry)),
      .DEPTH        (DEPTH),
      .ALMFULL_SLACK(ALMFULL_SLACK)
   ) c1Fifo (
      .clk     (clk),
      .reset   (rstInt),
      .enq_en  (afu_tx.c1.valid),
      .enq_data(c1EnqEntry),
      .deq_en  (c1Deq),
      .first   (c1Head),
      .notEmpty(c1NotEmpty),
      .almFull (c1AlmFull),
      .overflow(c1Overflow)
   );

   // The AFU sees the platform's responses untouched, but its back-pressure
   // comes from our own FIFO occupancy rather than the FIU's.
   always_comb begin
      afu_rx             = fiu_rx;
      afu_rx.c0TxAlmFull = c0AlmFull;
      afu_rx.c1TxAlmFull = c1AlmFull;
   end

   // Output registers: one valid pulse per pop; payload only loads on a pop.
   always_ff @(posedge clk or posedge rstInt) begin
      if (rstInt) begin
         fiu_tx <= '0;
      end else begin
         fiu_tx.c0.valid <= c0Deq;
         if (c0Deq) begin
            fiu_tx.c0.hdr <= c0Head;
         end
         fiu_tx.c1.valid <= c1Deq;
         if (c1Deq) begin
            fiu_tx.c1.hdr  <= c1Head.hdr;
            fiu_tx.c1.data <= c1Head.data;
         end
         fiu_tx.c2 <= afu_tx.c2;
      end
   end

`ifdef PLATFORM_UTILS_CCIP_TX_FIFO_OVERFLOW_CHECK_EN
   // Sticky: once any beat has been lost the stream is corrupt until reset.
   always_ff @(posedge clk or posedge rstInt) begin
      if (rstInt) begin
         error <= 1'b0;
      end else if (c0Overflow || c1Overflow) begin
         error <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rstInt && c0Overflow) begin
         $error("platform_utils_ccip_tx_fifo: c0 request dropped, FIFO full");
      end
      if (!rstInt && c1Overflow) begin
         $error("platform_utils_ccip_tx_fifo: c1 request dropped, FIFO full");
      end
   end
`endif
`else
   logic unusedOverflow;
   assign unusedOverflow = c0Overflow | c1Overflow;
   assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_platform_utils_ccip_tx_fifo.sv
// Self-checking bench for platform_utils_ccip_tx_fifo: directed corner cases plus
// randomized traffic against a queue-based reference of the buffering rules.
module tb_platform_utils_ccip_tx_fifo;
   import platform_utils_ccip_tx_fifo_pkg::*;

   localparam int DEPTH = 64;
   localparam int SLACK = 8;
   localparam int VW    = 640;
   localparam int C0W   = $bits(t_ccip_c0_ReqMemHdr);
   localparam int C1HW  = $bits(t_ccip_c1_ReqMemHdr);
   localparam int C2W   = $bits(t_if_ccip_c2_Tx);
   localparam int RXW   = $bits(t_if_ccip_Rx);

   logic        clk = 1'b0;
   logic        reset;
   t_if_ccip_Tx afuTx;
   t_if_ccip_Rx afuRx;
   t_if_ccip_Tx fiuTx;
   t_if_ccip_Rx fiuRx;
   logic        error;

   int vectorCount = 0;
   int missCount   = 0;

   t_c0_fifo_entry q0[$];
   t_c1_fifo_entry q1[$];
   logic           expV0, expV1, expAf0, expAf1;
   logic           expErr = 1'b0;
   t_c0_fifo_entry expHdr0;
   t_c1_fifo_entry expE1;
   t_if_ccip_c2_Tx expC2;

   always #5 clk = ~clk;

   platform_utils_ccip_tx_fifo #(
      .DEPTH        (DEPTH),
      .ALMFULL_SLACK(SLACK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .afu_tx(afuTx),
      .afu_rx(afuRx),
      .fiu_tx(fiuTx),
      .fiu_rx(fiuRx),
      .error (error)
   );

   task automatic checkOutput(input string tag, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [VW-1:0] randVec();
      logic [VW-1:0] v;
      for (int i = 0; i < VW / 32; i++) begin
         v[i*32 +: 32] = $urandom;
      end
      return v;
   endfunction

   // One clock of traffic: drive inputs, advance the reference, then compare.
   task automatic applyStimulus(input logic c0v, input logic c1v, input logic c2v,
                                input logic af0, input logic af1);
      logic [VW-1:0]  r;
      t_c1_fifo_entry e1;
      logic           drop;

      r = randVec();
      afuTx.c0.hdr   = r[C0W-1:0];
      afuTx.c0.valid = c0v;
      r = randVec();
      afuTx.c1.hdr   = r[C1HW-1:0];
      r = randVec();
      afuTx.c1.data  = r[CL_DATA_WIDTH-1:0];
      afuTx.c1.valid = c1v;
      r = randVec();
      afuTx.c2       = r[C2W-1:0];
      afuTx.c2.mmioRdValid = c2v;
      r = randVec();
      fiuRx             = r[RXW-1:0];
      fiuRx.c0TxAlmFull = af0;
      fiuRx.c1TxAlmFull = af1;
      #1;
      checkOutput("rxPassC0", VW'(afuRx.c0), VW'(fiuRx.c0));
      checkOutput("rxPassC1", VW'(afuRx.c1), VW'(fiuRx.c1));

      drop = 1'b0;
      if (c0v) begin
         if (q0.size() < DEPTH || (!af0 && q0.size() > 0)) q0.push_back(afuTx.c0.hdr);
         else drop = 1'b1;
      end
      expV0 = 1'b0;
      if (!af0 && q0.size() > 0) begin
         expHdr0 = q0.pop_front();
         expV0   = 1'b1;
      end
      expAf0 = (q0.size() >= DEPTH - SLACK);

      e1.hdr  = afuTx.c1.hdr;
      e1.data = afuTx.c1.data;
      if (c1v) begin
         if (q1.size() < DEPTH || (!af1 && q1.size() > 0)) q1.push_back(e1);
         else drop = 1'b1;
      end
      expV1 = 1'b0;
      if (!af1 && q1.size() > 0) begin
         expE1 = q1.pop_front();
         expV1 = 1'b1;
      end
      expAf1 = (q1.size() >= DEPTH - SLACK);
`ifdef PLATFORM_UTILS_CCIP_TX_FIFO_OVERFLOW_CHECK_EN
      if (drop) expErr = 1'b1;
`endif
      if (drop) $display("[TB] note: reference dropped a beat at %0t", $time);
      expC2 = afuTx.c2;

      @(posedge clk);
      #1;
      checkOutput("c0Valid", VW'(fiuTx.c0.valid), VW'(expV0));
      if (expV0) checkOutput("c0Hdr", VW'(fiuTx.c0.hdr), VW'(expHdr0));
      checkOutput("c1Valid", VW'(fiuTx.c1.valid), VW'(expV1));
      if (expV1) checkOutput("c1Beat", VW'({fiuTx.c1.hdr, fiuTx.c1.data}), VW'(expE1));
      checkOutput("c2Reg", VW'(fiuTx.c2), VW'(expC2));
      checkOutput("afuC0AlmFull", VW'(afuRx.c0TxAlmFull), VW'(expAf0));
      checkOutput("afuC1AlmFull", VW'(afuRx.c1TxAlmFull), VW'(expAf1));
      checkOutput("error", VW'(error), VW'(expErr));
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "C0Valid"}, VW'(fiuTx.c0.valid), VW'(1'b0));
      checkOutput({tag, "C1Valid"}, VW'(fiuTx.c1.valid), VW'(1'b0));
      checkOutput({tag, "C2Valid"}, VW'(fiuTx.c2.mmioRdValid), VW'(1'b0));
      checkOutput({tag, "C0AlmFull"}, VW'(afuRx.c0TxAlmFull), VW'(1'b0));
      checkOutput({tag, "C1AlmFull"}, VW'(afuRx.c1TxAlmFull), VW'(1'b0));
      checkOutput({tag, "Error"}, VW'(error), VW'(1'b0));
   endtask

   // Wait out the internal reset release with idle inputs; nothing may emerge.
   task automatic releaseReset();
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkQuiet("postRst");
      end
   endtask

   initial begin
      reset = 1'b1;
      afuTx = '0;
      fiuRx = '0;
      repeat (3) @(posedge clk);
      #1;
      checkQuiet("reset");
      releaseReset();

      // Single read with FIU ready: one-cycle latency, single pulse.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 56 writes held back by the FIU, then released.
      repeat (56) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (57) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Fill c0 and push one beat past full.
      repeat (65) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (65) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Full FIFO with continuous enqueue and dequeue.
      repeat (64) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (100) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (65) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset with 30 writes queued.
      repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      afuTx = '0;
      fiuRx = '0;
      reset = 1'b1;
      #1;
      checkQuiet("midRst");
      q0.delete();
      q1.delete();
      expErr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      releaseReset();
      repeat (40) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic, alternating light and heavy FIU back-pressure.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         int afPct;
         afPct = ((cyc / 100) % 2 == 0) ? 20 : 75;
         applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       ($urandom_range(99, 0) < afPct), ($urandom_range(99, 0) < afPct));
      end
      repeat (70) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("c0Drained", VW'(q0.size()), VW'(0));
      checkOutput("c1Drained", VW'(q1.size()), VW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
